// File: rtl/fetch_buffer.sv
// Instruction-fetch buffer: issues word-aligned reads for accepted PCs and queues in-order {pc, instr} pairs for decode.
// Optional FETCH_BUFFER_DROP_STATS_EN adds a drop_total counter of responses discarded after a flush.
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
`ifdef FETCH_BUFFER_DROP_STATS_EN
  ,
  output logic [31:0] drop_total
`endif
);

  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [DEPTH-1:0] alloc_q;
  logic [DEPTH-1:0] filled_q;
  logic [PTR_W-1:0] head_q, tail_q, fill_q;
  logic [CNT_W-1:0] count_q, drop_q;

  logic             space, accept, pop, rsp_drop, rsp_fill, flush_drop;
  logic [CNT_W-1:0] unfilled;
  logic [CNT_W:0]   flush_drops;

  // Dropped-but-outstanding responses still occupy memory slots, so they count against space.
  assign space         = ({1'b0, count_q} + {1'b0, drop_q}) < (CNT_W+1)'(DEPTH);
  assign pc_ready      = !reset && space && mem_req_ready && !flush;
  assign mem_req_valid = !reset && pc_valid && space && !flush;
  assign mem_req_addr  = {pc_in[31:2], 2'b00};
  assign accept        = pc_valid && pc_ready;

  assign out_valid = !reset && filled_q[head_q] && !flush;
  assign pop       = out_valid && out_ready;
  assign out_pc    = pc_q[head_q];
  assign out_instr = instr_q[head_q];

  assign rsp_drop = mem_rsp_valid && (drop_q != '0);
  assign rsp_fill = mem_rsp_valid && (drop_q == '0) && (count_q != '0)
                    && alloc_q[fill_q] && !filled_q[fill_q];

  always_comb begin
    unfilled = '0;
    for (int i = 0; i < DEPTH; i++)
      unfilled = unfilled + CNT_W'(alloc_q[i] && !filled_q[i]);
  end

  // A response arriving in the flush cycle belongs to the oldest in-flight request.
  assign flush_drops = {1'b0, drop_q} + {1'b0, unfilled};
  assign flush_drop  = mem_rsp_valid && (flush_drops != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alloc_q  <= '0;
      filled_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else if (flush) begin
      alloc_q  <= '0;
      filled_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      count_q  <= '0;
      drop_q   <= flush_drop ? CNT_W'(flush_drops - 1'b1) : CNT_W'(flush_drops);
    end else begin
      if (accept) begin
        pc_q[tail_q]     <= pc_in;
        alloc_q[tail_q]  <= 1'b1;
        filled_q[tail_q] <= 1'b0;
        tail_q           <= tail_q + PTR_W'(1);
      end
      if (rsp_drop)
        drop_q <= drop_q - CNT_W'(1);
      if (rsp_fill) begin
        instr_q[fill_q]  <= mem_rsp_data;
        filled_q[fill_q] <= 1'b1;
        fill_q           <= fill_q + PTR_W'(1);
      end
      if (pop) begin
        alloc_q[head_q]  <= 1'b0;
        filled_q[head_q] <= 1'b0;
        head_q           <= head_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(accept) - CNT_W'(pop);
    end
  end

`ifdef FETCH_BUFFER_DROP_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      drop_total <= '0;
    else if (flush ? flush_drop : rsp_drop)
      drop_total <= drop_total + 32'd1;
  end
`endif

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction-fetch stage directly downstream of the 32-bit load/count-by-4 program counter.
- Accepts PC values from the counter, issues word-aligned read requests to instruction memory, and holds the in-order responses in a DEPTH-entry circular buffer.
- Presents {pc, instr} pairs to decode over a valid/ready handshake.
- A flush (branch redirect, driven with the counter's load) discards all buffered and in-flight fetches.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, minimum 2.
- PTR_W, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all state
- pc_in  input  32  fetch address from the PC counter
- pc_valid  input  1  pc_in is valid this cycle
- pc_ready  output  1  block accepts pc_in this cycle
- flush  input  1  discard all buffered and outstanding fetches
- mem_req_valid  output  1  read request valid
- mem_req_addr  output  32  read address, {pc_in[31:2],2'b00}
- mem_req_ready  input  1  memory accepts the request
- mem_rsp_valid  input  1  read data returning; in order; no backpressure
- mem_rsp_data  input  32  instruction word
- out_valid  output  1  head entry holds a fetched instruction
- out_ready  input  1  decode consumes the head entry
- out_pc  output  32  PC of the head entry
- out_instr  output  32  instruction of the head entry

Behaviour:
- State:
  - entry[i] = {pc, instr, alloc, filled}.
  - Pointers: head (drain), tail (allocate), fill (next unfilled).
  - count = number of allocated entries, 0..DEPTH.
  - drop_cnt = number of in-flight responses to discard, 0..DEPTH.
- Reset: all alloc/filled bits 0; head, tail, fill, count, drop_cnt = 0. out_valid, mem_req_valid and pc_ready read 0 while reset is high. out_pc and out_instr read 0.
- space = (count + drop_cnt) < DEPTH.
- pc_ready = space && mem_req_ready && !flush. There is no combinational path from pc_valid to pc_ready.
- mem_req_valid = pc_valid && space && !flush.
- mem_req_addr is combinational from pc_in.
- Accept occurs when pc_valid && pc_ready. On accept:
  - entry[tail].pc <= pc_in (unmasked, low bits kept);
  - alloc <= 1, filled <= 0;
  - tail++ (wraps modulo DEPTH); count++.
- Response (mem_rsp_valid):
  - If drop_cnt > 0: drop_cnt--, data discarded.
  - Else if count > 0 and entry[fill] is unfilled: instr <= mem_rsp_data, filled <= 1, fill++.
  - Else (unsolicited response): ignored.
- Output:
  - out_valid = entry[head].filled && !flush.
  - out_pc and out_instr come from entry[head] (registered).
  - Pop occurs when out_valid && out_ready: alloc and filled cleared, head++, count--.
- Latency: a response in cycle N gives out_valid = 1 in cycle N+1. Memory must respond no earlier than the cycle after the request.
- Throughput: one instruction per cycle sustained when DEPTH >= memory latency + 1.
- Same-cycle accept, response and pop are all legal and independent. count_next = count + accept - pop.
- Full buffer: pc_ready = 0. A same-cycle pop does not raise pc_ready until the next cycle.
- Flush (takes priority over everything else in that cycle):
  - Let U = allocated-but-unfilled entries.
  - drop_cnt_next = drop_cnt + U - (mem_rsp_valid ? 1 : 0), where the response in the flush cycle consumes one drop.
  - All alloc/filled bits cleared; head = tail = fill = 0; count = 0.
  - No accept and no pop occur in the flush cycle.
  - The first post-flush PC can be accepted in the following cycle, provided space.
- Reset asserted mid-operation: immediate clear of all state; pending memory responses after reset are treated as unsolicited and ignored.
- Pointer wrap: modulo DEPTH, via natural PTR_W-bit overflow.

Optional Feature:
- Macro: FETCH_BUFFER_DROP_STATS_EN.
- When defined, the block adds an output port drop_total (32-bit) that counts every discarded response, i.e. each decrement of drop_cnt.
  - Reset value is 0.
  - Wraps from 0xFFFFFFFF to 0.
  - Does not count unsolicited responses.
- When not defined, the port and counter are absent. All other behaviour is identical.

Test Plan:
- Streaming:
  - Stimulus: PCs 0x00, 0x04, 0x08, 0x0C, 1-cycle memory latency, out_ready = 1.
  - Required: out_pc 0x00..0x0C in order with matching instr, one per cycle after 2-cycle fill latency.
- Backpressure:
  - Stimulus: out_ready = 0, DEPTH = 4, fetch 4 PCs with all responses returned.
  - Required: pc_ready = 0 with count = 4; one pop re-enables pc_ready the next cycle.
- Flush with in-flight fetches:
  - Stimulus: 3 requests outstanding (0x10, 0x14, 0x18), flush, then PC 0x100.
  - Required: 3 responses dropped; first out_pc = 0x100.
  - With FETCH_BUFFER_DROP_STATS_EN defined: drop_total = 3.
- Flush coincident with a response:
  - Stimulus: 2 outstanding, flush and mem_rsp_valid in the same cycle.
  - Required: drop_cnt = 1 after the flush; no stale output.
- Async reset mid-stream:
  - Stimulus: reset pulsed between clock edges with 2 entries filled.
  - Required: out_valid = 0 immediately; later unsolicited responses are ignored.
- Unaligned PC:
  - Stimulus: pc_in = 0x00000006.
  - Required: mem_req_addr = 0x00000004; out_pc = 0x00000006.
